// File: rtl/reset_vector_detector.sv
// Spots the 6502 reset sequence on the CPU bus and sends a bank-reset pulse to the mapper.
// It also latches the fetched reset vector and counts detections, saturating at 255.
module reset_vector_detector #(
   parameter int STACK_READS = 3,
   parameter int HOLD_CYCLES = 2
) (
   input  logic        m2,
   input  logic        reset,
   input  logic        romsel,
   input  logic        cpu_rw_in,
   input  logic [14:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   output logic        mapper_reset,
   output logic [15:0] reset_vector,
   output logic        vector_valid,
   output logic [7:0]  reset_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STK  = 2'd1,
      ST_VHI  = 2'd2
   } state_t;

   localparam logic [2:0] STACK_N = 3'(STACK_READS);
   localparam logic [3:0] HOLD_N  = 4'(HOLD_CYCLES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  last_sp_q, last_sp_d;
   logic [7:0]  vec_lo_q, vec_lo_d;
   logic [3:0]  hold_q, hold_d;
   logic        mapper_reset_q, mapper_reset_d;
   logic [15:0] reset_vector_q, reset_vector_d;
   logic        vector_valid_q, vector_valid_d;
   logic [7:0]  reset_count_q, reset_count_d;

   logic is_sr_s, is_lo_s, is_hi_s, descend_s, detect_s;

   always_comb begin
      is_sr_s   = cpu_rw_in & romsel & (cpu_addr_in[14:8] == 7'h01);
      is_lo_s   = cpu_rw_in & ~romsel & (cpu_addr_in == 15'h7FFC);
      is_hi_s   = cpu_rw_in & ~romsel & (cpu_addr_in == 15'h7FFD);
      descend_s = (cpu_addr_in[7:0] == (last_sp_q - 8'd1));

      state_d   = state_q;
      cnt_d     = cnt_q;
      last_sp_d = last_sp_q;
      vec_lo_d  = vec_lo_q;
      detect_s  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_sr_s) begin
               state_d   = ST_STK;
               cnt_d     = 3'd1;
               last_sp_d = cpu_addr_in[7:0];
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_STK: begin
            if (is_sr_s && descend_s) begin
               cnt_d     = (cnt_q >= STACK_N) ? STACK_N : (cnt_q + 3'd1);
               last_sp_d = cpu_addr_in[7:0];
            end else if (is_lo_s && (cnt_q == STACK_N)) begin
               state_d   = ST_VHI;
               vec_lo_d  = cpu_data_in;
            end else if (is_sr_s) begin
               cnt_d     = 3'd1;
               last_sp_d = cpu_addr_in[7:0];
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_VHI: begin
            if (is_hi_s) begin
               detect_s  = 1'b1;
               state_d   = ST_IDLE;
            end else if (is_sr_s) begin
               state_d   = ST_STK;
               cnt_d     = 3'd1;
               last_sp_d = cpu_addr_in[7:0];
            end else begin
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A detection reloads the pulse width even if a previous pulse is still running.
      if (detect_s) begin
         hold_d         = HOLD_N;
         reset_vector_d = {cpu_data_in, vec_lo_q};
         vector_valid_d = 1'b1;
         reset_count_d  = (reset_count_q == 8'hFF) ? 8'hFF : (reset_count_q + 8'd1);
      end else begin
         hold_d         = (hold_q != 4'd0) ? (hold_q - 4'd1) : 4'd0;
         reset_vector_d = reset_vector_q;
         vector_valid_d = vector_valid_q;
         reset_count_d  = reset_count_q;
      end
      mapper_reset_d = (hold_d != 4'd0);
   end

   always_ff @(negedge m2) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 3'd0;
         last_sp_q      <= 8'd0;
         vec_lo_q       <= 8'd0;
         hold_q         <= 4'd0;
         mapper_reset_q <= 1'b0;
         reset_vector_q <= 16'h0000;
         vector_valid_q <= 1'b0;
         reset_count_q  <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         last_sp_q      <= last_sp_d;
         vec_lo_q       <= vec_lo_d;
         hold_q         <= hold_d;
         mapper_reset_q <= mapper_reset_d;
         reset_vector_q <= reset_vector_d;
         vector_valid_q <= vector_valid_d;
         reset_count_q  <= reset_count_d;
      end
   end

   assign mapper_reset = mapper_reset_q;
   assign reset_vector = reset_vector_q;
   assign vector_valid = vector_valid_q;
   assign reset_count  = reset_count_q;

endmodule

// File: tb/tb_reset_vector_detector.sv
// Scoreboard bench: each bus cycle pushes its expected outputs, and a monitor compares them after the m2 falling edge.
module tb_reset_vector_detector;

   logic        m2 = 1'b0;
   logic        reset = 1'b1;
   logic        romsel = 1'b1;
   logic        cpu_rw_in = 1'b1;
   logic [14:0] cpu_addr_in = 15'h0000;
   logic [7:0]  cpu_data_in = 8'h00;
   logic        mr1, mr2, valid1, valid2;
   logic [15:0] vec1, vec2;
   logic [7:0]  cnt1, cnt2;

   int checks = 0;
   int errors = 0;

   always #5 m2 = ~m2;

   reset_vector_detector #(.STACK_READS(3), .HOLD_CYCLES(2)) dut (
      .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
      .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
      .mapper_reset(mr1), .reset_vector(vec1), .vector_valid(valid1), .reset_count(cnt1));

   // Longer pulse, so a second detection can land while the first pulse is still running.
   reset_vector_detector #(.STACK_READS(3), .HOLD_CYCLES(5)) dut_long (
      .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
      .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
      .mapper_reset(mr2), .reset_vector(vec2), .vector_valid(valid2), .reset_count(cnt2));

   typedef struct {
      logic        mr1;
      logic        mr2;
      logic [15:0] vec;
      logic        valid;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];

   int          e_hold1 = 0;
   int          e_hold2 = 0;
   logic [15:0] e_vec = 16'h0000;
   logic        e_valid = 1'b0;
   logic [7:0]  e_cnt = 8'd0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expected entry per sampled falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge m2);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("mapper_reset", {15'd0, mr1}, {15'd0, e.mr1});
            chk("mapper_reset_long", {15'd0, mr2}, {15'd0, e.mr2});
            chk("reset_vector", vec1, e.vec);
            chk("reset_vector_long", vec2, e.vec);
            chk("vector_valid", {15'd0, valid1}, {15'd0, e.valid});
            chk("vector_valid_long", {15'd0, valid2}, {15'd0, e.valid});
            chk("reset_count", {8'd0, cnt1}, {8'd0, e.cnt});
            chk("reset_count_long", {8'd0, cnt2}, {8'd0, e.cnt});
         end
      end
   end

   task automatic cyc(input logic rw, input logic rs, input logic [14:0] a, input logic [7:0] d,
                      input bit det, input logic [15:0] v, input bit rst);
      exp_t e;
      @(posedge m2);
      reset = rst;
      cpu_rw_in = rw;
      romsel = rs;
      cpu_addr_in = a;
      cpu_data_in = d;
      if (rst) begin
         e_hold1 = 0; e_hold2 = 0; e_vec = 16'h0000; e_valid = 1'b0; e_cnt = 8'd0;
      end else if (det) begin
         e_vec = v; e_valid = 1'b1;
         if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
         e_hold1 = 2; e_hold2 = 5;
      end else begin
         if (e_hold1 > 0) e_hold1--;
         if (e_hold2 > 0) e_hold2--;
      end
      e.mr1 = (e_hold1 != 0);
      e.mr2 = (e_hold2 != 0);
      e.vec = e_vec;
      e.valid = e_valid;
      e.cnt = e_cnt;
      sb.push_back(e);
   endtask

   task automatic sr(input logic [7:0] sp);
      cyc(1'b1, 1'b1, {7'h01, sp}, 8'hEE, 1'b0, 16'h0, 1'b0);
   endtask
   task automatic sw(input logic [7:0] sp);
      cyc(1'b0, 1'b1, {7'h01, sp}, 8'h55, 1'b0, 16'h0, 1'b0);
   endtask
   task automatic rom_rd(input logic [14:0] a, input logic [7:0] d, input bit det, input logic [15:0] v, input bit rst);
      cyc(1'b1, 1'b0, a, d, det, v, rst);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 15'h0000, 8'h00, 1'b0, 16'h0, 1'b0);
   endtask
   task automatic full_seq(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] v);
      sr(8'hFD); sr(8'hFC); sr(8'hFB);
      rom_rd(15'h7FFC, lo, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, hi, 1'b1, v, 1'b0);
   endtask

   initial begin
      int drain;
      cyc(1'b1, 1'b1, 15'h0000, 8'h00, 1'b0, 16'h0, 1'b1);
      cyc(1'b1, 1'b1, 15'h0000, 8'h00, 1'b0, 16'h0, 1'b1);
      idle(2);

      // Nominal reset sequence.
      full_seq(8'h00, 8'hC0, 16'hC000);
      idle(4);

      // Interrupt entry: stack writes, then NMI and IRQ vectors.
      sw(8'hFD); sw(8'hFC); sw(8'hFB);
      rom_rd(15'h7FFA, 8'h11, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFB, 8'h22, 1'b0, 16'h0, 1'b0);
      sw(8'hFD); sw(8'hFC); sw(8'hFB);
      rom_rd(15'h7FFE, 8'h33, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFF, 8'h44, 1'b0, 16'h0, 1'b0);
      idle(2);

      // Broken descent restarts the count, so the fetch is short.
      sr(8'hFD); sr(8'h50); sr(8'hFF);
      rom_rd(15'h7FFC, 8'h99, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, 8'h88, 1'b0, 16'h0, 1'b0);
      idle(1);

      // Stack pointer wraps $00 -> $FF.
      sr(8'h01); sr(8'h00); sr(8'hFF);
      rom_rd(15'h7FFC, 8'h34, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, 8'h12, 1'b1, 16'h1234, 1'b0);
      idle(3);

      // Short run, then an intervening non-stack read.
      sr(8'hFD); sr(8'hFC);
      rom_rd(15'h7FFC, 8'h00, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, 8'hC0, 1'b0, 16'h0, 1'b0);
      sr(8'hFD); sr(8'hFC); sr(8'hFB);
      idle(1);
      rom_rd(15'h7FFC, 8'h00, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, 8'hC0, 1'b0, 16'h0, 1'b0);
      idle(2);

      // Back-to-back detections; the long-pulse instance reloads while its hold is 1.
      full_seq(8'h78, 8'h56, 16'h5678);
      full_seq(8'hBC, 8'h9A, 16'h9ABC);
      idle(6);

      // Reset on the edge that samples $FFFD.
      sr(8'hFD); sr(8'hFC); sr(8'hFB);
      rom_rd(15'h7FFC, 8'h00, 1'b0, 16'h0, 1'b0);
      rom_rd(15'h7FFD, 8'hC0, 1'b0, 16'h0, 1'b1);
      idle(2);

      // Reset during the hold drops the pulse on that edge.
      full_seq(8'h00, 8'hE0, 16'hE000);
      idle(1);
      cyc(1'b1, 1'b1, 15'h0000, 8'h00, 1'b0, 16'h0, 1'b1);
      idle(2);

      // Saturation of the detection count.
      for (int i = 0; i < 260; i++) full_seq(8'h00, 8'hC0, 16'hC000);
      idle(6);

      drain = 0;
      while (sb.size() != 0 && drain < 10) begin
         @(negedge m2);
         drain++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_vector_detector.md
# reset_vector_detector

Watches the CPU bus, one sample per M2 cycle, for the 6502 reset sequence. That sequence is a run of consecutive, descending, read-only stack accesses at $01xx, followed immediately by reads of $FFFC and $FFFD. When the sequence completes, the block emits a bank-reset pulse to the downstream mapper register stage. That stage uses the pulse to restore power-on PRG/CHR bank state before the first opcode fetch from the reset vector. The block also latches the fetched vector and keeps a saturating count of detected resets for debug and LED use.

## Interface
Parameters:
- `STACK_READS`, default 3: number of consecutive descending stack reads required before the vector fetch (legal range 1–7).
- `HOLD_CYCLES`, default 2: width of `mapper_reset`, in M2 cycles (legal range 1–15).

Ports:
- `m2`, in, 1: CPU M2 clock. All state updates on the falling edge of `m2`.
- `reset`, in, 1: synchronous, active-high; sampled on the falling edge of `m2`.
- `romsel`, in, 1: /ROMSEL. Low means a $8000–$FFFF access.
- `cpu_rw_in`, in, 1: 1 = read, 0 = write.
- `cpu_addr_in`, in, 15: CPU A14..A0.
- `cpu_data_in`, in, 8: CPU data bus, valid at the falling edge of `m2`.
- `mapper_reset`, out, 1: active-high bank-reset request to the mapper register stage.
- `reset_vector`, out, 16: last captured reset vector, {hi, lo}.
- `vector_valid`, out, 1: set after the first complete detection.
- `reset_count`, out, 8: number of detections, saturating at 255.

## Operation
- Stack read (SR): `cpu_rw_in`=1, `romsel`=1, `cpu_addr_in[14:8]`=7'h01.
- LO fetch: `cpu_rw_in`=1, `romsel`=0, `cpu_addr_in`=15'h7FFC.
- HI fetch: `cpu_rw_in`=1, `romsel`=0, `cpu_addr_in`=15'h7FFD.
- Internal registers: `state` (IDLE, STK, VHI), `cnt` (3 bits), `last_sp` (8 bits), `vec_lo` (8 bits), `hold` (4 bits).
- Exactly one transition is evaluated per falling edge.
- IDLE:
  - SR → STK; `cnt`=1; `last_sp`=A[7:0].
  - Anything else → stay in IDLE.
- STK:
  - SR with A[7:0] == `last_sp`−1 (mod 256, so $00 → $FF wraps) → `cnt`=min(`cnt`+1, `STACK_READS`); `last_sp`=A[7:0].
  - LO fetch with `cnt`==`STACK_READS` → VHI; `vec_lo`=`cpu_data_in`.
  - SR not matching the descent → restart: `cnt`=1, `last_sp`=A[7:0].
  - Anything else, including any write or an LO fetch with a short count → IDLE.
- VHI:
  - HI fetch → detection, then IDLE.
  - SR → STK with `cnt`=1.
  - Otherwise → IDLE.
- Detection, on the same edge:
  - `reset_vector`={`cpu_data_in`, `vec_lo`}.
  - `vector_valid`=1.
  - `reset_count`=sat(`reset_count`+1).
  - `hold`=`HOLD_CYCLES`.
- `mapper_reset` = (`hold` != 0).
  - `hold` decrements on every falling edge where it is nonzero and no new detection occurs.
  - A detection while `hold` is nonzero reloads `hold` to `HOLD_CYCLES`.
- NMI/IRQ/BRK entry performs stack writes, so it never reaches VHI. Vector reads for those events are $FFFA/$FFFE.

## Timing
- `reset` high on a falling edge sets: `state`=IDLE, `cnt`=0, `last_sp`=0, `vec_lo`=0, `hold`=0.
- Resulting output values: `mapper_reset`=0, `reset_vector`=16'h0000, `vector_valid`=0, `reset_count`=0.
- `reset` has priority over every bus event on the same edge. A `reset` during STK or VHI abandons the sequence, and during a hold it drops `mapper_reset` on that edge.
- Latency: `mapper_reset` rises right after the falling edge that samples the HI fetch. It is therefore high for the whole next M2 cycle, which is the first opcode fetch at the vector.
- It stays high for exactly `HOLD_CYCLES` M2 cycles, then falls after the `HOLD_CYCLES`-th falling edge following detection.
- `reset_vector`, `vector_valid` and `reset_count` update on the detection edge and are otherwise stable.
- There is no combinational path from the inputs to any output; all outputs are registered.

## Test plan
- Reset sequence, nominal: SR $01FD, $01FC, $01FB; LO fetch with data $00; HI fetch with data $C0. Required:
  - `mapper_reset` high for 2 cycles.
  - `reset_vector`=$C000, `vector_valid`=1, `reset_count`=1.
- Interrupt entry: writes to $01FD/$01FC/$01FB, then reads of $FFFA/$FFFB. Required: no pulse and `reset_count` unchanged. Repeat with reads of $FFFE/$FFFF; same result.
- Broken descent and wrap: SR $01FD, $0150, $01FF … must restart the count.
  - SR $0101, $0100, $01FF, then $FFFC/$FFFD (data $34/$12) → detection with `reset_vector`=$1234.
- Short run: only 2 SRs before $FFFC with `STACK_READS`=3 → no detection. An intervening non-stack read between the last SR and $FFFC also → no detection.
- Back-to-back detections: a second full sequence while `hold`=1 → `mapper_reset` stays high for 2 more cycles. Force 256 detections → `reset_count` holds at 255.
- Reset mid-operation:
  - `reset` asserted on the edge sampling $FFFD → no detection; all outputs cleared.
  - `reset` asserted during the hold → `mapper_reset` low on that edge.
